// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-to-1 stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_STATIC  = 1'b0;
  localparam logic MODE_RR      = 1'b1;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 16;
  localparam int MAX_CHANNELS = 64;

  // OR-reduction encoder; result is only meaningful for a one-hot or zero input.
  function automatic logic [5:0] oh2idx(input logic [MAX_CHANNELS-1:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first request at or above ptr wins,
// wrapping modulo N; next_ptr points one past the winner.
module rr_arbiter #(
  parameter  int N  = 16,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  always_comb begin
    int   base;
    int   idx;
    logic found;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    // an out-of-range pointer cannot occur in normal use; treat it as zero
    base     = (int'(ptr) < N) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 valid/ready stream mux, static select or round-robin.
// Optional packet lock (in_last/out_last) enabled by STREAM_MUX_PKT_LOCK_EN.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready,
  output logic                      err_sel
);

  logic                load_en;
  logic                xfer;
  logic                sel_ok;
  logic [CHANNELS-1:0] rr_grant;
  logic [CHANNELS-1:0] st_grant;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    rr_next_ptr;
  logic [SEL_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]    mux_data;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SEL_W-1:0]    out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]    ptr_q,       ptr_d;
  logic                err_sel_q,   err_sel_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic                lock_q,      lock_d;
  logic [SEL_W-1:0]    lock_ch_q,   lock_ch_d;
  logic                out_last_q,  out_last_d;
  logic [CHANNELS-1:0] lock_oh;
  logic [SEL_W-1:0]    lock_inc;
  logic                last_bit;
`endif

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .req      (in_valid),
    .ptr      (ptr_q),
    .grant    (rr_grant),
    .next_ptr (rr_next_ptr)
  );

  // Grant selection and handshake
  always_comb begin
    sel_ok   = 32'(sel) < 32'(CHANNELS);
    st_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      st_grant[i] = sel_ok && (sel == SEL_W'(i)) && in_valid[i];
    end
    grant = (mode == MODE_RR) ? rr_grant : st_grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_oh = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lock_oh[i] = (lock_ch_q == SEL_W'(i));
    end
    if (lock_q) grant = in_valid & lock_oh;
`endif
    load_en  = !out_valid_q || out_ready;
    // rst gates ready directly so no handshake is seen while reset is held
    in_ready = (load_en && !rst) ? grant : '0;
    xfer     = |in_ready;
    gnt_idx  = SEL_W'(oh2idx(MAX_CHANNELS'(grant)));
    mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) mux_data = mux_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state for output register, pointer, error flag and lock
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    err_sel_d   = (mode == MODE_STATIC) && !sel_ok;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
    last_bit    = |(in_last & grant);
    lock_inc    = (lock_ch_q == SEL_W'(CHANNELS - 1)) ? '0 : lock_ch_q + SEL_W'(1);
`endif
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = mux_data;
        out_ch_d   = gnt_idx;
      end
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (xfer) begin
      out_last_d = last_bit;
      lock_d     = !last_bit;
      lock_ch_d  = gnt_idx;
      if (mode == MODE_RR && last_bit) ptr_d = lock_q ? lock_inc : rr_next_ptr;
    end
`else
    if (xfer && mode == MODE_RR) ptr_d = rr_next_ptr;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
      err_sel_q   <= 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
      err_sel_q   <= err_sel_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign err_sel   = err_sel_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
